part_1_bit_counter: RTL and testbench

//  Counts the 1-bits in an 8-bit switch operand using a 3-state ASM controller

---
 rtl/part_1_bit_counter.sv | 92 +++++++++
 tb/tb_part_1_bit_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/part_1_bit_counter.sv
// part_1_bit_counter: counts the 1-bits of an 8-bit switch operand.
// A three-state controller (idle / count / done) steers a right-shifting
// operand register and a 4-bit counter; the count is shown on HEX0.
module part_1_bit_counter (
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0
);

  typedef enum logic [1:0] {
    S1 = 2'd0,  // idle: track the switches
    S2 = 2'd1,  // count: shift operand out, add its LSB
    S3 = 2'd2   // done: hold result, raise done
  } state_t;

  logic       clk;
  logic       areset_n;
  logic       s;
  logic [7:0] a;
  logic [3:0] result;
  logic       done;
  state_t     state;

  assign clk      = KEY[0];
  assign areset_n = KEY[1];
  assign s        = SW[9];

  // KEY[3:2] and SW[8] have no function on this board top.
  logic unused_inputs;
  assign unused_inputs = ^{KEY[3:2], SW[8]};

  // Controller and datapath; done is registered so it is high exactly in S3.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state  <= S1;
      result <= '0;
      a      <= SW[7:0];
      done   <= 1'b0;
    end else begin
      case (state)
        S1: begin
          if (!s) begin
            a      <= SW[7:0];
            result <= '0;
          end else begin
            state <= S2;
          end
        end
        S2: begin
          if (a != '0) begin
            result <= result + {3'b000, a[0]};
            a      <= {1'b0, a[7:1]};
          end else begin
            state <= S3;
            done  <= 1'b1;
          end
        end
        S3: begin
          if (!s) begin
            state <= S1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S1;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign LEDR = {done, 9'b0};

  // Active-low seven-segment decode of the running count; 9..15 blank.
  always_comb begin
    HEX0 = 7'b1111111;
    case (result)
      4'd0: HEX0 = 7'b1000000;
      4'd1: HEX0 = 7'b1111001;
      4'd2: HEX0 = 7'b0100100;
      4'd3: HEX0 = 7'b0110000;
      4'd4: HEX0 = 7'b0011001;
      4'd5: HEX0 = 7'b0010010;
      4'd6: HEX0 = 7'b0000010;
      4'd7: HEX0 = 7'b1111000;
      4'd8: HEX0 = 7'b0000000;
      default: HEX0 = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_part_1_bit_counter.sv
// Bench for part_1_bit_counter: directed and random operands, expected
// counts/latencies derived from popcount and highest-set-bit arithmetic.
module tb_part_1_bit_counter;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] key_hi = '0;
  logic [9:0] sw     = '0;
  logic [3:0] key;
  logic [9:0] ledr;
  logic [6:0] hex0;

  int checks = 0;
  int errors = 0;

  assign key = {key_hi, rst_n, clk};

  part_1_bit_counter part_1 (
    .KEY  (key),
    .SW   (sw),
    .LEDR (ledr),
    .HEX0 (hex0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 2 ns later; unused inputs get noise.
  task automatic step();
    @(posedge clk);
    #2;
    key_hi = 2'($urandom);
    sw[8]  = 1'($urandom);
  endtask

  task automatic check_out(input string tag, input bit exp_done, input int exp_res);
    check({tag, "_done"}, {31'd0, ledr[9]}, {31'd0, exp_done});
    check({tag, "_led"}, {23'd0, ledr[8:0]}, 32'd0);
    check({tag, "_hex"}, {25'd0, hex0}, {25'd0, seg(exp_res)});
  endtask

  // Idle edge with s=0 loads the operand.
  task automatic load(input logic [7:0] op);
    sw[7:0] = op;
    sw[9]   = 1'b0;
    step();
    check_out("load", 1'b0, 0);
  endtask

  // Operand already held in A, FSM idle: raise s and follow the whole count.
  task automatic count(input logic [7:0] op);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) if (op[i]) k = i + 1;
    sw[9] = 1'b1;
    step();
    check_out("enter_s2", 1'b0, 0);
    for (int j = 1; j <= k; j++) begin
      sw[7:0] = 8'($urandom);
      step();
      check_out("shift", 1'b0, $countones(op & 8'((1 << j) - 1)));
    end
    step();
    check_out("done", 1'b1, $countones(op));
    sw[7:0] = 8'($urandom);
    step();
    check_out("hold", 1'b1, $countones(op));
    sw[9] = 1'b0;
    step();
    check("leave_done", {31'd0, ledr[9]}, 32'd0);
    step();
    check_out("cleared", 1'b0, 0);
  endtask

  initial begin
    // Reset with 0xAA on the switches; reset itself loads A.
    rst_n   = 1'b0;
    sw[7:0] = 8'hAA;
    sw[9]   = 1'b0;
    step();
    step();
    check_out("reset", 1'b0, 0);
    rst_n = 1'b1;
    count(8'hAA);

    load(8'h00); count(8'h00);
    load(8'hFF); count(8'hFF);
    load(8'h01); count(8'h01);
    load(8'h81); count(8'h81);
    load(8'h80); count(8'h80);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] op;
      op = 8'($urandom);
      load(op);
      count(op);
    end

    // Reset mid-count: next edge must show the reset condition, and with s=1
    // afterwards the operand captured at reset (not the live switches) counts.
    load(8'hF0);
    sw[9] = 1'b1;
    step();
    step();
    sw[7:0] = 8'h3C;
    rst_n   = 1'b0;
    step();
    check_out("rst_mid", 1'b0, 0);
    rst_n   = 1'b1;
    sw[7:0] = 8'hC3;
    count(8'h3C);

    // Reset mid-count with s low afterwards: stays idle until a new s=1.
    load(8'hF0);
    sw[9] = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    sw[9] = 1'b0;
    step();
    check_out("rst_mid2", 1'b0, 0);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      sw[7:0] = 8'($urandom);
      step();
      check_out("idle", 1'b0, 0);
    end
    load(8'h5A);
    count(8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
